// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_sync input-conditioning block: FSM state
// encoding and the glitch counter width.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CHECK_HI  = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CHECK_LO  = 2'd3
  } debounce_state_e;

  localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser with synchronous active-high reset for bringing
// asynchronous levels into the clk domain.
module sync2_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a raw level; outputs a clean level, its complement and edge strobes.
// Optional glitch counter enabled by defining DEBOUNCE_SYNC_GLITCH_CNT_EN.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  input  logic                hold,
  output logic                dout,
  output logic                dout_bar,
  output logic                rise,
  output logic                fall
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic            w_sync;
  debounce_state_e r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic            r_dout, w_dout;
  logic            r_dout_bar;
  logic            r_rise, w_rise;
  logic            r_fall, w_fall;
  logic            w_abort;

  sync2_ff #(
    .WIDTH (1)
  ) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (din),
    .o_q     (w_sync)
  );

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_dout  = r_dout;
    w_rise  = 1'b0;
    w_fall  = 1'b0;
    w_abort = 1'b0;
    // Strobes stay single-cycle even when hold freezes everything else.
    if (!hold) begin
      unique case (r_state)
        ST_STABLE_LO: begin
          if (w_sync) begin
            w_state = ST_CHECK_HI;
            w_cnt   = CNT_W'(1);
          end else begin
            w_cnt = '0;
          end
        end
        ST_CHECK_HI: begin
          if (!w_sync) begin
            w_state = ST_STABLE_LO;
            w_cnt   = '0;
            w_abort = 1'b1;
          end else if (r_cnt == CntLast) begin
            w_state = ST_STABLE_HI;
            w_dout  = 1'b1;
            w_rise  = 1'b1;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE_HI: begin
          if (!w_sync) begin
            w_state = ST_CHECK_LO;
            w_cnt   = CNT_W'(1);
          end else begin
            w_cnt = '0;
          end
        end
        ST_CHECK_LO: begin
          if (w_sync) begin
            w_state = ST_STABLE_HI;
            w_cnt   = '0;
            w_abort = 1'b1;
          end else if (r_cnt == CntLast) begin
            w_state = ST_STABLE_LO;
            w_dout  = 1'b0;
            w_fall  = 1'b1;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state = ST_STABLE_LO;
          w_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_STABLE_LO;
      r_cnt      <= '0;
      r_dout     <= 1'b0;
      r_dout_bar <= 1'b1;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_dout     <= w_dout;
      r_dout_bar <= ~w_dout;
      r_rise     <= w_rise;
      r_fall     <= w_fall;
    end
  end

  assign dout     = r_dout;
  assign dout_bar = r_dout_bar;
  assign rise     = r_rise;
  assign fall     = r_fall;

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_glitch <= '0;
    end else if (w_abort && (r_glitch != {GLITCH_W{1'b1}})) begin
      r_glitch <= r_glitch + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch;
`else
  logic w_unused_abort;
  assign w_unused_abort = w_abort;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with STABLE_CYCLES=4.
// Glitch counter checks are active when DEBOUNCE_SYNC_GLITCH_CNT_EN is defined.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic reset, din, hold;
  logic dout, dout_bar, rise, fall;
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .hold     (hold),
    .dout     (dout),
    .dout_bar (dout_bar),
    .rise     (rise),
    .fall     (fall)
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_dout, input logic e_rise,
                           input logic e_fall);
    check({tag, ".dout"}, {7'd0, dout}, {7'd0, e_dout});
    check({tag, ".dout_bar"}, {7'd0, dout_bar}, {7'd0, ~e_dout});
    check({tag, ".rise"}, {7'd0, rise}, {7'd0, e_rise});
    check({tag, ".fall"}, {7'd0, fall}, {7'd0, e_fall});
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    hold  = 1'b0;
    step();
    step();
    check_out("reset", 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    check("reset.glitch", glitch_cnt, 8'd0);
`endif
    reset = 1'b0;

    // Clean rise: dout changes after edge 5, strobe lasts one cycle.
    din = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_out("rise_wait", 1'b0, 1'b0, 1'b0);
    end
    step();
    check_out("rise_edge5", 1'b1, 1'b1, 1'b0);
    step();
    check_out("rise_edge6", 1'b1, 1'b0, 1'b0);

    // 3-cycle low pulse: aborts on the final check cycle.
    din = 1'b0;
    step();
    step();
    step();
    din = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_out("pulse_lo", 1'b1, 1'b0, 1'b0);
    end
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    check("pulse_lo.glitch", glitch_cnt, 8'd1);
`endif

    // Clean fall.
    din = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_out("fall_wait", 1'b1, 1'b0, 1'b0);
    end
    step();
    check_out("fall_edge5", 1'b0, 1'b0, 1'b1);
    step();
    check_out("fall_edge6", 1'b0, 1'b0, 1'b0);

    // Toggle every cycle: 10 aborted high checks, dout stays low.
    din = 1'b0;
    for (int k = 0; k < 20; k++) begin
      din = ~din;
      step();
      check_out("toggle", 1'b0, 1'b0, 1'b0);
    end
    din = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("toggle_settle", 1'b0, 1'b0, 1'b0);
    end
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    check("toggle.glitch", glitch_cnt, 8'd11);
`endif

    // Hold for 10 edges mid-check (cnt=2): count is frozen, so dout rises after edge 15.
    din = 1'b1;
    for (int k = 0; k < 4; k++) step();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_out("hold_frozen", 1'b0, 1'b0, 1'b0);
    end
    hold = 1'b0;
    step();
    check_out("hold_edge14", 1'b0, 1'b0, 1'b0);
    step();
    check_out("hold_edge15", 1'b1, 1'b1, 1'b0);
    step();
    check_out("hold_edge16", 1'b1, 1'b0, 1'b0);

    // Hold on the cycle a fall would fire: no transition, no strobe until released.
    din = 1'b0;
    for (int k = 0; k < 5; k++) step();
    hold = 1'b1;
    step();
    check_out("hold_strobe0", 1'b1, 1'b0, 1'b0);
    step();
    check_out("hold_strobe1", 1'b1, 1'b0, 1'b0);
    hold = 1'b0;
    step();
    check_out("hold_release", 1'b0, 1'b0, 1'b1);
    step();
    check_out("hold_after", 1'b0, 1'b0, 1'b0);

    // Reset while in CHECK_HI with cnt=3, then re-qualify from scratch.
    din = 1'b1;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    check_out("midreset", 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    check("midreset.glitch", glitch_cnt, 8'd0);
`endif
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_out("midreset_wait", 1'b0, 1'b0, 1'b0);
    end
    step();
    check_out("midreset_rise", 1'b1, 1'b1, 1'b0);

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    // Over 300 aborted low checks: counter saturates.
    din = 1'b1;
    for (int k = 0; k < 640; k++) begin
      din = ~din;
      step();
    end
    din = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("saturate.glitch", glitch_cnt, 8'hFF);
    check_out("saturate", 1'b1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
